rle_expand_32: RTL and testbench
================================

Name: rle_expand_32

Overview:
- Inverse of the JPEG run-length merge stage: takes one merged 32-coefficient RLE descriptor (leading zeros, trailing zeros, non-zero flag, entry array, entry count).
- Streams the 32 reconstructed coefficients out serially, one per accepted beat, with valid/ready on both sides.
- Sits between the RLE/entropy decode path and the inverse zig-zag/IDCT buffer; one descriptor in, 32 beats out.

Parameters:
- N_COEF, 32, coefficients per descriptor.
- ENT_W, 14, entry width: [13:8] zero run before value, [7:0] signed coefficient.
- RUN_W, 6, zero-run field width.
- VAL_W, 8, coefficient width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  block can accept a descriptor.
- in_flag  in  1  0 = all 32 coefficients zero; other fields ignored.
- in_left  in  5  leading zeros before first entry.
- in_right  in  5  trailing zeros after last entry.
- in_size  in  6  entries used, 0..32.
- in_array  in  448  entries; entry k at [k*14 +: 14]; entry in_size-1 is emitted first.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts.
- out_coef  out  8  signed coefficient.
- out_idx  out  5  coefficient position 0..31.
- out_last  out  1  high on position 31.
- fmt_err  out  1  one-cycle pulse with the last beat when the descriptor total is not 32.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid, out_coef, out_idx, out_last and fmt_err are 0; all captured registers cleared. Reset mid-stream abandons the descriptor without emitting further beats.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture all inputs and go to LEAD.
  - LEAD: emit zeros while lead_cnt < in_left.
  - RUN: current entry k, starting at in_size-1. Emit run_cnt zeros, then the value, then decrement k. After k=0 completes, go to TRAIL.
  - TRAIL: emit zeros until position 31.
  - State skips: LEAD with in_left=0 goes to RUN; RUN with in_size=0 goes to TRAIL.
- Handshake and timing:
  - Descriptor accept to first out_valid: 1 cycle.
  - Full throughput: 1 coefficient/cycle while out_ready=1.
  - out_* holds stable while out_valid&&!out_ready.
  - in_ready=0 from capture until the out_last beat is accepted. in_ready=1 the following cycle; no overlap between descriptors.
- Position counter pos: 0..31, increments on each out handshake. out_idx=pos; out_last=(pos==31).
- Termination is by pos only:
  - Stream ends after beat 31 regardless of state; remaining entries and zeros are discarded (truncation).
  - If entries and zeros run out before pos 31, fill the remaining positions with zeros.
- fmt_err:
  - total = in_left + in_right + min(in_size,32) + sum of run fields of the used entries, computed and registered at capture (9-bit).
  - fmt_err=1 on the out_last handshake iff flag=1 and total≠32, or in_size>32.
- flag=0: emit 32 zeros; fmt_err=0.
- in_size>32: clamp to 32 entries.
- An entry with value 0 is legal; emit it as a coefficient.
- An entry with run=0 emits its value immediately.
- Runs up to 31 are supported.

Decomposition:
- Package rle_pkg:
  - Constants N_COEF, ENT_W, RUN_W, VAL_W, ARR_W=448.
  - Entry field slice positions (RUN_LSB=8).
  - FSM state enum {IDLE, LEAD, RUN, TRAIL}.
- Sub-module rle_entry_sel: combinational 32:1 mux returning the run and value of entry k from the captured array. Reused by the total-sum logic through a separate adder tree in the top level.

Test Plan:
- flag=0, left=0, right=0, size=0, out_ready=1 -> 32 beats of 0, idx 0..31, out_last on beat 31, fmt_err=0, in_ready=1 the next cycle.
- flag=1, left=3, right=27, size=2, entry1={0,0x05}, entry0={0,0xFB} -> idx3=0x05, idx4=0xFB, all other positions 0, fmt_err=0.
- flag=1, left=0, right=26, size=2, entry1={0,0x10}, entry0={4,0x7F} -> idx0=0x10, idx1..4=0, idx5=0x7F, rest 0; random out_ready stalls give identical data with stable outputs while stalled.
- flag=1, left=31, right=5, size=1, entry0={0,0x01} (total 37) -> idx31=0, value truncated, fmt_err pulses with out_last.
- flag=1, left=2, right=0, size=1, entry0={0,0x80} (total 3) -> idx2=0x80, idx3..31 zero-filled, fmt_err=1 on the last beat.
- rst_n pulsed low at beat 10 of a descriptor -> outputs 0 immediately, in_ready=1; the next descriptor decodes from idx 0 correctly.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared constants, entry field layout and FSM state type for the RLE expander.
package rle_pkg;

  localparam int N_COEF  = 32;
  localparam int ENT_W   = 14;
  localparam int RUN_W   = 6;
  localparam int VAL_W   = 8;
  localparam int ARR_W   = N_COEF * ENT_W;   // 448
  localparam int RUN_LSB = 8;
  localparam int VAL_LSB = 0;
  localparam int IDX_W   = 5;
  localparam int SIZE_W  = 6;
  localparam int TOT_W   = 9;
  // Wide enough for 32 maximal runs plus left/right/size without wrapping.
  localparam int SUM_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    RUN   = 2'd2,
    TRAIL = 2'd3
  } state_e;

  // Entry counts above 32 are treated as exactly 32 entries.
  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
    return (s > SIZE_W'(N_COEF)) ? SIZE_W'(N_COEF) : s;
  endfunction

endpackage

// File: rtl/rle_entry_sel.sv
// 32:1 selector returning the run and value fields of one descriptor entry.
module rle_entry_sel
  import rle_pkg::*;
(
  input  logic [ARR_W-1:0] array_i,
  input  logic [IDX_W-1:0] sel_i,
  output logic [RUN_W-1:0] run_o,
  output logic [VAL_W-1:0] val_o
);

  logic [ENT_W-1:0] ent [N_COEF];

  genvar gi;
  generate
    for (gi = 0; gi < N_COEF; gi++) begin : g_split
      assign ent[gi] = array_i[gi*ENT_W +: ENT_W];
    end
  endgenerate

  logic [ENT_W-1:0] ent_sel;
  assign ent_sel = ent[sel_i];
  assign run_o   = ent_sel[RUN_LSB +: RUN_W];
  assign val_o   = ent_sel[VAL_LSB +: VAL_W];

endmodule

// File: rtl/rle_expand_32.sv
// Expands one merged 32-coefficient RLE descriptor into 32 serial coefficients.
// Beat data is decoded from registered state only, so it holds steady under
// backpressure and the first beat appears the cycle after the descriptor is taken.
module rle_expand_32
  import rle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_flag,
  input  logic [IDX_W-1:0]   in_left,
  input  logic [IDX_W-1:0]   in_right,
  input  logic [SIZE_W-1:0]  in_size,
  input  logic [ARR_W-1:0]   in_array,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VAL_W-1:0]   out_coef,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               fmt_err
);

  // Captured descriptor and stream position.
  state_e             state_q;
  logic [IDX_W-1:0]   pos_q;
  logic [IDX_W-1:0]   lead_cnt_q;
  logic [IDX_W-1:0]   k_q;
  logic [RUN_W-1:0]   run_cnt_q;
  logic [IDX_W-1:0]   left_q;
  logic               flag_q;
  logic               size_nz_q;
  logic               size_ovf_q;
  logic [TOT_W-1:0]   total_q;
  logic [ARR_W-1:0]   array_q;

  // ---------------------------------------------------------------------------
  // Descriptor total, evaluated on the raw inputs so it can be registered at capture.
  // ---------------------------------------------------------------------------
  logic [SIZE_W-1:0]  size_c;
  logic [SIZE_W-1:0]  size_m1;
  logic [RUN_W-1:0]   run_masked [N_COEF];
  logic [SUM_W-1:0]   run_sum;
  logic [SUM_W-1:0]   total_full;
  logic [TOT_W-1:0]   total_d;

  assign size_c  = clamp_size(in_size);
  assign size_m1 = size_c - SIZE_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_COEF; gi++) begin : g_run_mask
      // Only entries actually used by the descriptor contribute their runs.
      assign run_masked[gi] = (SIZE_W'(gi) < size_c)
                              ? in_array[gi*ENT_W + RUN_LSB +: RUN_W]
                              : '0;
    end
  endgenerate

  // Sum of the run fields of all used entries.
  always_comb begin
    run_sum = '0;
    for (int i = 0; i < N_COEF; i++) begin
      run_sum = run_sum + {{(SUM_W-RUN_W){1'b0}}, run_masked[i]};
    end
  end

  assign total_full = {{(SUM_W-IDX_W){1'b0}}, in_left}
                    + {{(SUM_W-IDX_W){1'b0}}, in_right}
                    + {{(SUM_W-SIZE_W){1'b0}}, size_c}
                    + run_sum;
  // Saturate so a huge total can never alias back onto 32 in the 9-bit register.
  assign total_d = (total_full > SUM_W'((1 << TOT_W) - 1))
                   ? TOT_W'((1 << TOT_W) - 1)
                   : total_full[TOT_W-1:0];

  // ---------------------------------------------------------------------------
  // Current entry and beat decode.
  // ---------------------------------------------------------------------------
  logic [RUN_W-1:0] cur_run;
  logic [VAL_W-1:0] cur_val;
  logic             cur_is_value;
  logic             out_fire;

  rle_entry_sel u_entry_sel (
    .array_i (array_q),
    .sel_i   (k_q),
    .run_o   (cur_run),
    .val_o   (cur_val)
  );

  // Inside RUN the entry's zeros come first; once they are exhausted the value is due.
  assign cur_is_value = (state_q == RUN) && (run_cnt_q >= cur_run);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign out_coef  = cur_is_value ? cur_val : '0;
  assign out_idx   = pos_q;
  assign out_last  = out_valid && (pos_q == IDX_W'(N_COEF - 1));
  assign out_fire  = out_valid && out_ready;
  assign fmt_err   = out_fire && out_last && flag_q
                     && ((total_q != TOT_W'(N_COEF)) || size_ovf_q);

  // Descriptor capture, per-beat sequencing and position tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      lead_cnt_q <= '0;
      k_q        <= '0;
      run_cnt_q  <= '0;
      left_q     <= '0;
      flag_q     <= 1'b0;
      size_nz_q  <= 1'b0;
      size_ovf_q <= 1'b0;
      total_q    <= '0;
      array_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pos_q      <= '0;
            lead_cnt_q <= '0;
            run_cnt_q  <= '0;
            k_q        <= size_m1[IDX_W-1:0];
            left_q     <= in_left;
            flag_q     <= in_flag;
            size_nz_q  <= (size_c != '0);
            size_ovf_q <= (in_size > SIZE_W'(N_COEF));
            total_q    <= total_d;
            array_q    <= in_array;
            // An all-zero block just emits zero fill; empty phases are skipped.
            if (!in_flag)
              state_q <= TRAIL;
            else if (in_left != '0)
              state_q <= LEAD;
            else if (size_c != '0)
              state_q <= RUN;
            else
              state_q <= TRAIL;
          end
        end

        default: begin
          if (out_fire) begin
            if (pos_q == IDX_W'(N_COEF - 1)) begin
              // Position 31 always ends the block, whatever is left over.
              state_q <= IDLE;
              pos_q   <= '0;
            end else begin
              pos_q <= pos_q + IDX_W'(1);
              case (state_q)
                LEAD: begin
                  if (IDX_W'(lead_cnt_q + IDX_W'(1)) == left_q)
                    state_q <= size_nz_q ? RUN : TRAIL;
                  else
                    lead_cnt_q <= lead_cnt_q + IDX_W'(1);
                end
                RUN: begin
                  if (cur_is_value) begin
                    run_cnt_q <= '0;
                    if (k_q == '0)
                      state_q <= TRAIL;
                    else
                      k_q <= k_q - IDX_W'(1);
                  end else begin
                    run_cnt_q <= run_cnt_q + RUN_W'(1);
                  end
                end
                default: ;  // TRAIL: zero fill until position 31
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_expand_32.sv
// Scoreboard bench for rle_expand_32: directed descriptors push their expected
// 32 beats into a queue, and a monitor pops and compares on every output handshake.
module tb_rle_expand_32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_flag = 1'b0;
  logic [4:0]   in_left = '0;
  logic [4:0]   in_right = '0;
  logic [5:0]   in_size = '0;
  logic [447:0] in_array = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_coef;
  logic [4:0]   out_idx;
  logic         out_last;
  logic         fmt_err;

  rle_expand_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flag   (in_flag),
    .in_left   (in_left),
    .in_right  (in_right),
    .in_size   (in_size),
    .in_array  (in_array),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .fmt_err   (fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] coef;
    logic [4:0] idx;
    logic       last;
    logic       err;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    beat_cnt = 0;
  bit    stall_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Downstream backpressure: random when stalls are enabled, otherwise always ready.
  always @(posedge clk) begin
    #1;
    out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: one line per accepted beat, plus stall stability checks.
  logic       stall_prev = 1'b0;
  logic [7:0] prev_coef;
  logic [4:0] prev_idx;
  logic       prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_coef", out_coef, prev_coef);
        check("stall_idx", out_idx, prev_idx);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got idx %0d coef 0x%02h, required no beat", out_idx, out_coef);
        end else begin
          e = exp_q.pop_front();
          $display("beat idx=%0d coef=0x%02h last=%0d err=%0d", out_idx, out_coef, out_last, fmt_err);
          check("coef", out_coef, e.coef);
          check("idx", out_idx, e.idx);
          check("last", out_last, e.last);
          check("fmt_err", fmt_err, e.err);
          beat_cnt++;
        end
      end else begin
        check("fmt_err_quiet", fmt_err, 0);
      end
      stall_prev = out_valid && !out_ready;
      prev_coef  = out_coef;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  logic [7:0]   ev [32];
  logic [447:0] arr;

  task automatic clr_exp();
    foreach (ev[i]) ev[i] = 8'h00;
    arr = '0;
  endtask

  task automatic put_ent(input int k, input logic [5:0] run, input logic [7:0] val);
    arr[k*14 +: 14] = {run, val};
  endtask

  // Issue one descriptor (called just after a rising edge) and queue its beats.
  task automatic send(input logic flag, input logic [4:0] left, input logic [4:0] right,
                      input logic [5:0] size, input logic err);
    beat_t b;
    int    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    in_flag  = flag;
    in_left  = left;
    in_right = right;
    in_size  = size;
    in_array = arr;
    in_valid = 1'b1;
    for (int p = 0; p < 32; p++) begin
      b.coef = ev[p];
      b.idx  = 5'(p);
      b.last = (p == 31);
      b.err  = (p == 31) ? err : 1'b0;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("desc flag=%0d left=%0d right=%0d size=%0d accepted", flag, left, right, size);
    check("first_valid", out_valid, 1);
    check("busy_in_ready", in_ready, 0);
  endtask

  // Wait for the queued beats to drain, then check the block is idle again.
  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
      exp_q.delete();
    end
    check("ready_after", in_ready, 1);
    check("idle_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int t;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_coef", out_coef, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_fmt_err", fmt_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // flag=0: all zeros, no error
    clr_exp();
    send(1'b0, 5'd0, 5'd0, 6'd0, 1'b0);
    wait_done();

    // Two run-0 entries after 3 leading zeros
    clr_exp();
    put_ent(1, 6'd0, 8'h05);
    put_ent(0, 6'd0, 8'hFB);
    ev[3] = 8'h05;
    ev[4] = 8'hFB;
    send(1'b1, 5'd3, 5'd27, 6'd2, 1'b0);
    wait_done();

    // Entry with a 4-zero run, under random backpressure
    clr_exp();
    put_ent(1, 6'd0, 8'h10);
    put_ent(0, 6'd4, 8'h7F);
    ev[0] = 8'h10;
    ev[5] = 8'h7F;
    stall_en = 1'b1;
    send(1'b1, 5'd0, 5'd26, 6'd2, 1'b0);
    wait_done();
    stall_en = 1'b0;

    // 31 leading zeros then a run of 1: value falls past position 31 (total 38)
    clr_exp();
    put_ent(0, 6'd1, 8'h01);
    send(1'b1, 5'd31, 5'd5, 6'd1, 1'b1);
    wait_done();

    // Short descriptor (total 3): zero fill to 31 and error
    clr_exp();
    put_ent(0, 6'd0, 8'h80);
    ev[2] = 8'h80;
    send(1'b1, 5'd2, 5'd0, 6'd1, 1'b1);
    wait_done();

    // Zero-valued entry is a real coefficient (total 0+28+3+1 = 32)
    clr_exp();
    put_ent(2, 6'd1, 8'h00);
    put_ent(1, 6'd0, 8'h80);
    put_ent(0, 6'd0, 8'h01);
    ev[2] = 8'h80;
    ev[3] = 8'h01;
    send(1'b1, 5'd0, 5'd28, 6'd3, 1'b0);
    wait_done();

    // in_size=40 clamps to 32 entries; entry k holds k+1, so position p carries 32-p
    clr_exp();
    for (int k = 0; k < 32; k++) put_ent(k, 6'd0, 8'(k + 1));
    for (int p = 0; p < 32; p++) ev[p] = 8'(32 - p);
    send(1'b1, 5'd0, 5'd0, 6'd40, 1'b1);
    wait_done();

    // Reset after beat 10 abandons the descriptor
    clr_exp();
    put_ent(1, 6'd0, 8'h05);
    put_ent(0, 6'd0, 8'hFB);
    ev[3] = 8'h05;
    ev[4] = 8'hFB;
    start = beat_cnt;
    send(1'b1, 5'd3, 5'd27, 6'd2, 1'b0);
    t = 0;
    while ((beat_cnt - start) < 10 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("reset_at_beat", beat_cnt - start, 10);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    $display("reset asserted mid-stream");
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_coef", out_coef, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 0);

    // Next descriptor after reset decodes from position 0
    clr_exp();
    put_ent(1, 6'd0, 8'h10);
    put_ent(0, 6'd4, 8'h7F);
    ev[0] = 8'h10;
    ev[5] = 8'h7F;
    send(1'b1, 5'd0, 5'd26, 6'd2, 1'b0);
    wait_done();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
